// File: rtl/mtr_drv_pkg.sv
// rtl/mtr_drv_pkg.sv - shared constants and types for the motor-drive PWM stage
package mtr_drv_pkg;

    typedef logic [10:0] duty_t;

    localparam duty_t PWM_MAX        = 11'h7FF;
    localparam duty_t DUTY_MID       = 11'h400;
    localparam duty_t NONOVERLAP_DEF = 11'h020;
    localparam duty_t SLEW_STEP_DEF  = 11'd16;

    // Two's complement speed to offset-binary duty: -1024 -> 0, 0 -> mid, +1023 -> max
    function automatic duty_t spd_to_tgt(input logic [10:0] spd);
        return {~spd[10], spd[9:0]};
    endfunction

endpackage

// File: rtl/mtr_drv_if.sv
// rtl/mtr_drv_if.sv - speed command and PWM drive bundle between PID and motor stage
interface mtr_drv_if;
    logic        mtr_en;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        lftPWM1;
    logic        lftPWM2;
    logic        rghtPWM1;
    logic        rghtPWM2;
    logic        prd_strt;

    modport master (
        output mtr_en, lft_spd, rght_spd,
        input  lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt
    );

    modport slave (
        input  mtr_en, lft_spd, rght_spd,
        output lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt
    );
endinterface

// File: rtl/mtr_drv_pwm_pair.sv
// rtl/mtr_drv_pwm_pair.sv - one motor's duty latch and dead-timed complementary PWM pair (MTR_SLEW_LIMIT_EN adds slew limiting)
module pwm_pair
    import mtr_drv_pkg::*;
#(
    parameter duty_t NONOVERLAP = NONOVERLAP_DEF
`ifdef MTR_SLEW_LIMIT_EN
    ,
    parameter duty_t SLEW_STEP  = SLEW_STEP_DEF
`endif
) (
    input  logic  clk,
    input  logic  rst_n,
    input  duty_t cnt,
    input  logic  wrap,
    input  duty_t tgt,
    input  logic  mtr_en,
    output logic  pwm1,
    output logic  pwm2
);

    duty_t       duty_cur;
    duty_t       duty_nxt;
    logic [11:0] pwm2_on;
    logic        pwm1_nxt;
    logic        pwm2_nxt;

`ifdef MTR_SLEW_LIMIT_EN
    logic [11:0] up_sum;
    logic [11:0] dn_diff;

    always_comb begin
        up_sum   = {1'b0, duty_cur} + {1'b0, SLEW_STEP};
        dn_diff  = {1'b0, duty_cur} - {1'b0, SLEW_STEP};
        duty_nxt = tgt;
        // Clip the final step so the latch lands exactly on target
        if (tgt > duty_cur) begin
            if (up_sum < {1'b0, tgt})
                duty_nxt = up_sum[10:0];
        end else if (tgt < duty_cur) begin
            if (duty_cur > SLEW_STEP && dn_diff > {1'b0, tgt})
                duty_nxt = dn_diff[10:0];
        end
    end
`else
    always_comb begin
        duty_nxt = tgt;
    end
`endif

    // Low side turns on NONOVERLAP after the high side drops; a sum past 0x7FE keeps it off all period
    always_comb begin
        pwm2_on  = {1'b0, duty_cur} + {1'b0, NONOVERLAP};
        pwm1_nxt = mtr_en && (cnt >= NONOVERLAP) && (cnt < duty_cur);
        pwm2_nxt = mtr_en && ({1'b0, cnt} >= pwm2_on) && (cnt != PWM_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_cur <= DUTY_MID;
            pwm1     <= 1'b0;
            pwm2     <= 1'b0;
        end else begin
            if (wrap)
                duty_cur <= duty_nxt;
            pwm1 <= pwm1_nxt;
            pwm2 <= pwm2_nxt;
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// rtl/mtr_drv.sv - dual H-bridge PWM driver with shared period counter (MTR_SLEW_LIMIT_EN enables duty slew limiting)
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter duty_t NONOVERLAP = NONOVERLAP_DEF,
    parameter duty_t SLEW_STEP  = SLEW_STEP_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    mtr_drv_if.slave  bus
);

    duty_t cnt;
    logic  wrap;

    assign wrap = (cnt == PWM_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            bus.prd_strt <= 1'b0;
        end else begin
            cnt          <= cnt + 11'd1;
            bus.prd_strt <= wrap;
        end
    end

    pwm_pair #(
        .NONOVERLAP (NONOVERLAP)
`ifdef MTR_SLEW_LIMIT_EN
        ,
        .SLEW_STEP  (SLEW_STEP)
`endif
    ) u_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt    (cnt),
        .wrap   (wrap),
        .tgt    (spd_to_tgt(bus.lft_spd)),
        .mtr_en (bus.mtr_en),
        .pwm1   (bus.lftPWM1),
        .pwm2   (bus.lftPWM2)
    );

    pwm_pair #(
        .NONOVERLAP (NONOVERLAP)
`ifdef MTR_SLEW_LIMIT_EN
        ,
        .SLEW_STEP  (SLEW_STEP)
`endif
    ) u_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt    (cnt),
        .wrap   (wrap),
        .tgt    (spd_to_tgt(bus.rght_spd)),
        .mtr_en (bus.mtr_en),
        .pwm1   (bus.rghtPWM1),
        .pwm2   (bus.rghtPWM2)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// tb/tb_mtr_drv.sv - self-checking bench for mtr_drv against a period-level behavioural model
module tb_mtr_drv;

    localparam int NO   = 32;
    localparam int STEP = 16;
    localparam int PMAX = 2047;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mtr_drv_if bus ();

    mtr_drv #(
        .NONOVERLAP (11'h020),
        .SLEW_STEP  (11'd16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int m_cnt;
    int m_duty [2];
    int a_hi1 [2], a_hi2 [2], p_hi1 [2], p_hi2 [2];
    int a_ov, p_ov, a_prd, p_prd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tgt_of(input logic [10:0] s);
        return int'($signed(s)) + 1024;
    endfunction

    function automatic int nxt_duty(input int c, input int t);
`ifdef MTR_SLEW_LIMIT_EN
        if (t > c) return c + (((t - c) < STEP) ? (t - c) : STEP);
        return c - (((c - t) < STEP) ? (c - t) : STEP);
`else
        return t;
`endif
    endfunction

    function automatic int hi1(input int d);
        return (d > NO) ? d - NO : 0;
    endfunction

    function automatic int hi2(input int d);
        return (d + NO <= 2046) ? 2046 - (d + NO) + 1 : 0;
    endfunction

    task automatic clr_acc();
        for (int i = 0; i < 2; i++) begin
            a_hi1[i] = 0;
            a_hi2[i] = 0;
        end
        a_ov  = 0;
        a_prd = 0;
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_duty[0] = 1024;
        m_duty[1] = 1024;
        clr_acc();
    endtask

    task automatic step();
        int   e1 [2];
        int   e2 [2];
        int   prev;
        logic en;
        logic [4:0] exp_v;
        logic [4:0] got_v;
        @(posedge clk);
        en = bus.mtr_en;
        for (int i = 0; i < 2; i++) begin
            e1[i] = (en && m_cnt >= NO && m_cnt < m_duty[i]) ? 1 : 0;
            e2[i] = (en && m_cnt >= m_duty[i] + NO && m_cnt <= 2046) ? 1 : 0;
        end
        exp_v = {(m_cnt == PMAX), e1[0] != 0, e2[0] != 0, e1[1] != 0, e2[1] != 0};
        prev  = m_cnt;
        if (prev == PMAX) begin
            m_duty[0] = nxt_duty(m_duty[0], tgt_of(bus.lft_spd));
            m_duty[1] = nxt_duty(m_duty[1], tgt_of(bus.rght_spd));
        end
        m_cnt = (m_cnt + 1) % 2048;
        @(negedge clk);
        got_v = {bus.prd_strt, bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2};
        chk("pwm_out", {27'd0, got_v}, {27'd0, exp_v});
        a_hi1[0] += int'(bus.lftPWM1);
        a_hi2[0] += int'(bus.lftPWM2);
        a_hi1[1] += int'(bus.rghtPWM1);
        a_hi2[1] += int'(bus.rghtPWM2);
        a_ov     += int'((bus.lftPWM1 & bus.lftPWM2) | (bus.rghtPWM1 & bus.rghtPWM2));
        a_prd    += int'(bus.prd_strt);
        if (prev == PMAX) begin
            p_hi1 = a_hi1;
            p_hi2 = a_hi2;
            p_ov  = a_ov;
            p_prd = a_prd;
            clr_acc();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int v);
        int guard;
        guard = 0;
        while (m_cnt != v && guard < 4096) begin
            step();
            guard++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out", {27'd0, bus.prd_strt, bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.mtr_en   = 1'b1;
        bus.lft_spd  = 11'h000;
        bus.rght_spd = 11'h000;
        model_reset();

        // Reset and 50 % duty
        @(negedge clk);
        do_reset();
        run(4096);
        chk("mid_lhi1", p_hi1[0], 992);
        chk("mid_lhi2", p_hi2[0], 991);
        chk("mid_rhi1", p_hi1[1], 992);
        chk("mid_rhi2", p_hi2[1], 991);
        chk("mid_ovl",  p_ov, 0);
        chk("mid_prd",  p_prd, 1);

`ifndef MTR_SLEW_LIMIT_EN
        // Extremes
        run_to(0);
        bus.lft_spd  = 11'h400;
        bus.rght_spd = 11'h3FF;
        run(4096);
        chk("ext_lhi1", p_hi1[0], 0);
        chk("ext_lhi2", p_hi2[0], 2015);
        chk("ext_rhi1", p_hi1[1], 2015);
        chk("ext_rhi2", p_hi2[1], 0);
        chk("ext_ovl",  p_ov, 0);
        run_to(0);
        bus.lft_spd  = 11'h000;
        bus.rght_spd = 11'h000;
        run(2048);
`endif

        // Mid-period command change
        run_to(12'h200);
        bus.lft_spd = 11'h100;
        run_to(0);
        chk("chg_cur_lhi1", p_hi1[0], 992);
        run(2048);
`ifdef MTR_SLEW_LIMIT_EN
        chk("chg_nxt_lhi1", p_hi1[0], hi1(1024 + STEP));
        chk("chg_nxt_lhi2", p_hi2[0], hi2(1024 + STEP));
`else
        chk("chg_nxt_lhi1", p_hi1[0], 1248);
        chk("chg_nxt_lhi2", p_hi2[0], 735);
`endif
        chk("chg_rhi1", p_hi1[1], 992);
        chk("chg_rhi2", p_hi2[1], 991);

        // Enable drop and resume
        run_to(12'h300);
        bus.mtr_en = 1'b0;
        step();
        chk("en_off", {28'd0, bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2}, 32'd0);
        run_to(12'h100);
        chk("en_still_off", {31'd0, bus.lftPWM1}, 32'd0);
        bus.mtr_en = 1'b1;
        step();
        chk("en_on_l", {31'd0, bus.lftPWM1}, 32'd1);
        chk("en_on_r", {31'd0, bus.rghtPWM1}, 32'd1);

        // Reset mid-operation, then slew / direct step to full forward
        bus.lft_spd  = 11'h3FF;
        bus.rght_spd = 11'h3FF;
        run_to(0);
        run_to(12'h500);
        do_reset();
        run(2048);
        chk("rst_lhi1", p_hi1[0], 992);
        chk("rst_rhi1", p_hi1[1], 992);
`ifdef MTR_SLEW_LIMIT_EN
        for (int k = 1; k <= 4; k++) begin
            run(2048);
            chk("slew_lhi1", p_hi1[0], hi1(1024 + STEP * k));
        end
`else
        run(2048);
        chk("step_lhi1", p_hi1[0], 2015);
        chk("step_lhi2", p_hi2[0], 0);
`endif

        // Randomized commands, enables and one asynchronous reset
        for (int seg = 0; seg < 10; seg++) begin
            bus.lft_spd  = ($urandom % 5 == 0) ? 11'h400 : 11'($urandom);
            bus.rght_spd = ($urandom % 5 == 0) ? 11'h3FF : 11'($urandom);
            bus.mtr_en   = ($urandom % 4) != 0;
            run($urandom_range(50, 4000));
            if (seg == 6) begin
                do_reset();
                run(5);
            end
        end
        bus.mtr_en = 1'b1;
        run_to(0);
        run(2048);
        chk("rnd_ovl", p_ov, 0);
        chk("rnd_prd", p_prd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mtr_drv.md
# mtr_drv

Motor-drive stage that sits directly downstream of the PID steering controller. It takes the signed 11-bit left/right wheel speed commands and converts each into a complementary pair of PWM signals with fixed dead time for the H-bridge gate drivers. Duty updates only at period boundaries, so outputs never glitch mid-period. An optional slew limiter bounds how far the duty can move per period.

## Interface

**Parameters**
- NONOVERLAP, default 11'h020: dead time in clocks between one leg of a pair turning off and the other turning on.
- SLEW_STEP, default 11'd16: maximum duty change per PWM period. Used only when slew limiting is compiled in.

**Ports**
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mtr_en  in  1  motor enable; low forces all PWM outputs low
- lft_spd  in  11  signed left speed command from PID (two's complement)
- rght_spd  in  11  signed right speed command from PID (two's complement)
- lftPWM1  out  1  left high-side drive
- lftPWM2  out  1  left low-side drive
- rghtPWM1  out  1  right high-side drive
- rghtPWM2  out  1  right low-side drive
- prd_strt  out  1  one-clock pulse in the cycle the counter equals 11'h000

## Operation

- **Counter:** one shared 11-bit free-running counter `cnt` that wraps from 0x7FF to 0x000. Period is 2048 clocks.
- **Target duty:** `tgt = {~spd[10], spd[9:0]}` (offset binary). spd 0 → 0x400 (50 %). spd −1024 → 0x000. spd +1023 → 0x7FF.
- **Duty latch:** `duty_cur` per motor, loaded only in the cycle where `cnt == 0x7FF`. Input changes at any other time have no effect until the next wrap.
- **PWM1 (high side):** the registered output is high iff NONOVERLAP ≤ cnt < duty_cur in the previous cycle.
- **PWM2 (low side):** the registered output is high iff (duty_cur + NONOVERLAP) ≤ cnt ≤ 0x7FE in the previous cycle.
  - The sum is computed 12 bits wide. If it exceeds 0x7FE, PWM2 stays low for the whole period.
- **Dead time:** PWM1 and PWM2 are never high in the same cycle.
  - The gap at the duty edge is NONOVERLAP clocks.
  - The gap at the wrap is NONOVERLAP+1 clocks (cnt 0x7FF through NONOVERLAP−1).
- **mtr_en low:** all four PWM outputs are low from the next clock edge. The counter and duty latches keep running.
- **mtr_en rising edge:** outputs resume from the current cnt position using the same rules. There is no forced period restart.

## Timing

- **Reset values:** cnt = 0x000, duty_cur = 0x400 (both motors), all PWM outputs 0, prd_strt = 0.
- **prd_strt:** registered, asserted in the clock after cnt changes 0x7FF→0x000.
- **Output latency:** PWM outputs lag the cnt compare by exactly 1 clock.
- **Command latency:** a speed change takes effect 1 to 2048 clocks later, at the first wrap.
- **Reset mid-period:** asynchronous return to the reset values. The first period after release uses duty 0x400.

## Configuration

- Macro: `MTR_SLEW_LIMIT_EN`.
- **Defined:** at each wrap, `duty_cur` moves toward `tgt` by min(|tgt − duty_cur|, SLEW_STEP).
  - The arithmetic is unsigned 11-bit with 12-bit intermediate.
  - `duty_cur` never overshoots `tgt`.
- **Not defined:** at each wrap, `duty_cur` loads `tgt` directly. SLEW_STEP is unused.

## Structure

- **Package `mtr_drv_pkg`:**
  - period constant PWM_MAX = 11'h7FF
  - DUTY_MID = 11'h400
  - a `duty_t` typedef (logic [10:0])
  - the default NONOVERLAP and SLEW_STEP values
- **Sub-module `pwm_pair`:** one instance per motor. It takes cnt, the wrap strobe, tgt and mtr_en, and holds its own duty latch, optional slew logic, and the PWM1/PWM2 registers.
- **Top:** `mtr_drv` owns the counter, prd_strt and the two instances.

## Test plan

1. **Reset and 50 %:** hold reset, release with spd = 0 on both motors and mtr_en = 1.
   - Per period, PWM1 is high for cnt 0x020–0x3FF (992 clocks).
   - PWM2 is high for cnt 0x420–0x7FE (991 clocks).
   - PWM1 and PWM2 never overlap.
   - prd_strt fires every 2048 clocks.
2. **Extremes:** spd = 11'h400 (−1024) gives PWM1 never high and PWM2 high for cnt 0x020–0x7FE. spd = 11'h3FF gives PWM1 high for cnt 0x020–0x7FE and PWM2 never high.
3. **Mid-period change:** change lft_spd from 0 to 0x100 at cnt = 0x200.
   - The current period keeps duty 0x400.
   - The next period gives PWM1 high for cnt 0x020–0x4FF.
   - rght outputs are unaffected.
4. **Enable:** deassert mtr_en at cnt = 0x300. All outputs go low 1 clock later and cnt is unaffected. Reassert at cnt = 0x100 and PWM1 goes high 1 clock later.
5. **Slew (MTR_SLEW_LIMIT_EN):** step spd from 0 to 0x3FF.
   - duty_cur reads 0x410, 0x420, … on successive periods.
   - It reaches 0x7FF after 64 periods, and the last step is clipped to 0x00F.
   - Without the macro, it reaches 0x7FF at the first wrap.
6. **Reset mid-operation:** with spd = 0x3FF, assert rst_n at cnt = 0x500. All outputs are 0 immediately, and after release cnt restarts at 0 with duty 0x400.
